// File: rtl/cpu_pkg.sv
// Constants and types shared by the register file and the destination-select mux.
package cpu_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;
   localparam reg_addr_t REG_SP   = 5'd29;
   localparam reg_addr_t REG_RA   = 5'd31;

   localparam logic [DATA_W-1:0] SP_RESET = 32'd227;

   // Destination-select encoding used by the mux that feeds WriteReg.
   typedef enum logic [2:0] {
      DST_RT = 3'd0,
      DST_RD = 3'd1,
      DST_SP = 3'd2,
      DST_RA = 3'd3,
      DST_RS = 3'd4
   } dst_sel_e;

   function automatic logic is_zero_reg(input reg_addr_t addr);
      return addr == REG_ZERO;
   endfunction

   function automatic reg_addr_t dst_addr(input dst_sel_e sel,
                                          input reg_addr_t rs,
                                          input reg_addr_t rt,
                                          input reg_addr_t rd);
      reg_addr_t a;
      a = rt;
      case (sel)
         DST_RT:  a = rt;
         DST_RD:  a = rd;
         DST_SP:  a = REG_SP;
         DST_RA:  a = REG_RA;
         DST_RS:  a = rs;
         default: a = rt;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: 32:1 mux, optional write bypass, $zero forcing.
module reg_read_port
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter bit          BYPASS = 1'b0
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic [REG_AW-1:0]               addr,
   input  logic                            wr_en,
   input  logic [REG_AW-1:0]               wr_addr,
   input  logic [DATA_W-1:0]               wr_data,
   output logic [DATA_W-1:0]               data_c
);

   logic hit_c;

   // $zero wins over the bypass path so address 0 can never leak WriteData.
   always_comb begin
      hit_c  = BYPASS && wr_en && (wr_addr == addr);
      data_c = regs[addr];
      if (hit_c) begin
         data_c = wr_data;
      end
      if (is_zero_reg(addr)) begin
         data_c = '0;
      end
   end

endmodule

// File: rtl/reg_bank.sv
// 32 x DATA_W register file: one synchronous write port, two combinational read ports.
module reg_bank
   import cpu_pkg::*;
#(
   parameter int unsigned        DATA_W   = cpu_pkg::DATA_W,
   parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(cpu_pkg::SP_RESET),
   parameter bit                 BYPASS   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [4:0]        ReadReg1,
   input  logic [4:0]        ReadReg2,
   input  logic [4:0]        WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic                            wr_en_c;

   // Reset has priority over a pending write, including for the bypass path.
   assign wr_en_c = RegWrite && !reset;

   // Register array; $sp comes out of reset pointing at the stack base.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (REG_AW'(i) == REG_SP) ? SP_RESET : '0;
         end
      end else if (RegWrite && !is_zero_reg(WriteReg)) begin
         regs[WriteReg] <= WriteData;
      end
   end

   reg_read_port #(
      .DATA_W (DATA_W),
      .BYPASS (BYPASS)
   ) u_rd1 (
      .regs    (regs),
      .addr    (ReadReg1),
      .wr_en   (wr_en_c),
      .wr_addr (WriteReg),
      .wr_data (WriteData),
      .data_c  (ReadData1)
   );

   reg_read_port #(
      .DATA_W (DATA_W),
      .BYPASS (BYPASS)
   ) u_rd2 (
      .regs    (regs),
      .addr    (ReadReg2),
      .wr_en   (wr_en_c),
      .wr_addr (WriteReg),
      .wr_data (WriteData),
      .data_c  (ReadData2)
   );

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: both bypass variants run side by side against an array model.
module tb_reg_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  ReadReg1, ReadReg2, WriteReg;
   logic [31:0] WriteData;
   logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   logic [31:0] mem  [32];
   logic [31:0] snap [32];

   always #5 clk = ~clk;

   reg_bank #(.BYPASS(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
      .WriteData(WriteData), .ReadData1(rd1_0), .ReadData2(rd2_0)
   );

   reg_bank #(.BYPASS(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
      .WriteData(WriteData), .ReadData1(rd1_1), .ReadData2(rd2_1)
   );

   // Architectural model: reset image, then plain array writes skipping $zero.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) mem[i] = (i == 29) ? 32'd227 : 32'd0;
      end else if (RegWrite && WriteReg != 5'd0) begin
         mem[WriteReg] = WriteData;
      end
   end

   function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && RegWrite && !reset && a == WriteReg) return WriteData;
      return mem[a];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_rd1_b0", rd1_0, exp_read(ReadReg1, 1'b0));
         chk("cyc_rd2_b0", rd2_0, exp_read(ReadReg2, 1'b0));
         chk("cyc_rd1_b1", rd1_1, exp_read(ReadReg1, 1'b1));
         chk("cyc_rd2_b1", rd2_1, exp_read(ReadReg2, 1'b1));
      end
   end

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
      RegWrite  = we;
      WriteReg  = wa;
      WriteData = wd;
      ReadReg1  = r1;
      ReadReg2  = r2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd29, 5'd5);
      tick();
      tick();
      check_en = 1'b1;
      #1;
      chk("rst_sp_b0",    rd1_0, 32'd227);
      chk("rst_r5_b0",    rd2_0, 32'd0);
      chk("rst_sp_b1",    rd1_1, 32'd227);
      chk("rst_r5_b1",    rd2_1, 32'd0);
      chk("model_sp",     mem[29], 32'd227);
      reset = 1'b0;
      drive(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd29);
      tick();

      // basic write: old value before the edge, new value after
      drive(1'b1, 5'd8, 32'h12345678, 5'd8, 5'd8);
      #2;
      chk("wr8_before", rd1_0, 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
      #2;
      chk("wr8_rd1", rd1_0, 32'h12345678);
      chk("wr8_rd2", rd2_0, 32'h12345678);

      // $zero, with and without bypass
      tick();
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      #2;
      chk("zero_b0_pre", rd1_0, 32'd0);
      chk("zero_b1_pre", rd1_1, 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      #2;
      chk("zero_b0_post", rd1_0, 32'd0);
      chk("zero_b1_post", rd1_1, 32'd0);

      // $ra then $sp on consecutive cycles
      tick();
      drive(1'b1, 5'd31, 32'h100, 5'd31, 5'd29);
      tick();
      drive(1'b1, 5'd29, 32'h200, 5'd28, 5'd30);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd29);
      #2;
      chk("ra_val", rd1_0, 32'h100);
      chk("sp_val", rd2_0, 32'h200);
      ReadReg1 = 5'd28;
      ReadReg2 = 5'd30;
      #1;
      chk("r28_clean", rd1_0, 32'd0);
      chk("r30_clean", rd2_0, 32'd0);

      // same-cycle read/write hazard on reg 10
      tick();
      drive(1'b1, 5'd10, 32'hAAAA, 5'd0, 5'd10);
      tick();
      drive(1'b1, 5'd10, 32'h5555, 5'd0, 5'd10);
      #2;
      chk("haz_b0_old", rd2_0, 32'hAAAA);
      chk("haz_b1_new", rd2_1, 32'h5555);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd10);
      #2;
      chk("haz_b0_after", rd2_0, 32'h5555);

      // asynchronous reset mid-cycle overrides a pending write
      tick();
      drive(1'b1, 5'd5, 32'h11, 5'd5, 5'd8);
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd8);
      #2;
      chk("r5_pre_rst", rd1_0, 32'h11);
      tick();
      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd29);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_r5_b0", rd1_0, 32'd0);
      chk("arst_sp_b0", rd2_0, 32'd227);
      chk("arst_r5_b1", rd1_1, 32'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd8);
      #2;
      chk("arst_r5_after", rd1_0, 32'd0);
      chk("arst_r8_after", rd2_0, 32'd0);

      // populate every register with a distinct value
      for (int i = 1; i < 32; i++) begin
         tick();
         drive(1'b1, 5'(i), 32'h01010101 * 32'(i) + 32'h0F00, 5'(i), 5'(31 - i));
      end
      tick();
      drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd29);
      #2;
      chk("fill_r7",  rd1_0, 32'h07070707 + 32'h0F00);
      chk("fill_r29", rd2_0, 32'h1D1D1D1D + 32'h0F00);
      for (int i = 0; i < 32; i++) snap[i] = mem[i];

      // writes disabled: random addresses and data must not disturb state
      for (int i = 0; i < 100; i++) begin
         tick();
         drive(1'b0, 5'($urandom_range(0, 31)), $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 32; i++) begin
         tick();
         ReadReg1 = 5'(i);
         ReadReg2 = 5'(31 - i);
         #2;
         chk("dump_rd1_b0", rd1_0, (i == 0) ? 32'd0 : snap[i]);
         chk("dump_rd2_b1", rd2_1, (i == 31) ? 32'd0 : snap[31 - i]);
      end

      tick();
      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
